// File: rtl/aes_pkg.sv
// aes_pkg
//   Shared definitions for the iterative AES key schedule:
//   - SBOX      : forward AES S-box (FIPS-197)
//   - xtime()   : multiply by x in GF(2^8), polynomial 0x11B
//   - nk_of / nr_of / nw_of : NK, NR, NW derived from a key size in bits
//   - ks_state_e: key-schedule FSM state encoding
package aes_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } ks_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int unsigned nk_of(input int unsigned key_bits);
        return key_bits / 32;
    endfunction

    function automatic int unsigned nr_of(input int unsigned key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic int unsigned nw_of(input int unsigned key_bits);
        return 4 * (key_bits / 32 + 7);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word
//   32-bit SubWord: four parallel combinational S-box lookups.
//   word_in  : input word
//   word_out : S-box applied to each byte of word_in
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    always_comb begin
        word_out = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            word_out[8*b +: 8] = SBOX[word_in[8*b +: 8]];
        end
    end

endmodule

// File: rtl/aes_key_schedule.sv
// aes_key_schedule
//   Iterative AES key expansion (128/192/256-bit keys), one 32-bit schedule
//   word per unstalled clock, round keys delivered on a valid/ready stream.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     key_valid/key_ready   : key handshake (key_ready only while idle)
//     key_in [KEY_BITS-1:0] : key, word i at [32i+31:32i]
//     flush                 : synchronous abort back to idle
//     rk_valid/rk_ready     : round-key handshake
//     rk_data [127:0]       : {w[4r+3], w[4r+2], w[4r+1], w[4r]}
//     rk_index [3:0]        : round number r
//     rk_last               : high with rk_valid on the final round key
//   Build option: AES_KS_ZEROIZE_EN clears window, collector, rk_data and
//   rcon after the last key is taken or after a flush.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                flush,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk_data,
    output logic [3:0]          rk_index,
    output logic                rk_last
);

    localparam int unsigned NK = nk_of(KEY_BITS);
    localparam int unsigned NR = nr_of(KEY_BITS);
    localparam int unsigned NW = nw_of(KEY_BITS);

    localparam logic [5:0] NK_W    = 6'(NK);
    localparam logic [5:0] NW_W    = 6'(NW);
    localparam logic [2:0] NK_M1_W = 3'(NK - 1);
    localparam logic [3:0] NR_W    = 4'(NR);

    ks_state_e   state_q, state_d;
    logic        ready_en_q, ready_en_d;
    logic [31:0] win_q [NK];
    logic [31:0] win_d [NK];
    logic [31:0] col_q [3];
    logic [31:0] col_d [3];
    logic [1:0]  col_cnt_q, col_cnt_d;
    logic [5:0]  idx_q, idx_d;
    logic [2:0]  mod_q, mod_d;
    logic [7:0]  rcon_q, rcon_d;
    logic [3:0]  round_q, round_d;
    logic        rk_valid_q, rk_valid_d;
    logic [127:0] rk_data_q, rk_data_d;
    logic [3:0]  rk_index_q, rk_index_d;
    logic        rk_last_q, rk_last_d;

    logic [31:0] win_old, win_prev, sub_in, sub_out, new_word;
    logic        accept, rk_fire, can_xfer, gen, last_fire;

    // The window doubles as the key register: words 0..NK-1 are produced by
    // rotating the loaded key through it, so after NK steps it holds
    // w[0..NK-1] in place and the recurrence needs no separate key path.
    assign win_old  = win_q[0];
    assign win_prev = win_q[NK-1];

    // One S-box block serves both the RotWord path (i%NK==0) and the
    // SubWord-only path used by 256-bit keys (i%NK==4).
    assign sub_in = (mod_q == 3'd0) ? {win_prev[23:0], win_prev[31:24]} : win_prev;

    aes_sub_word u_sub_word (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    always_comb begin
        new_word = win_old ^ win_prev;
        if (idx_q < NK_W) begin
            new_word = win_old;
        end else if (mod_q == 3'd0) begin
            new_word = win_old ^ sub_out ^ {rcon_q, 24'h0};
        end else if (NK == 8 && mod_q == 3'd4) begin
            new_word = win_old ^ sub_out;
        end
    end

    assign accept    = (state_q == ST_IDLE) && ready_en_q && key_valid && !flush;
    assign rk_fire   = rk_valid_q && rk_ready;
    assign can_xfer  = !rk_valid_q || rk_ready;
    // Completing a round key needs the output slot; otherwise hold the counter.
    assign gen       = (state_q == ST_EXPAND) && (idx_q < NW_W) && !flush &&
                       ((col_cnt_q != 2'd3) || can_xfer);
    assign last_fire = (state_q == ST_EXPAND) && rk_fire && rk_last_q && !flush;

    always_comb begin
        state_d    = state_q;
        ready_en_d = 1'b1;
        win_d      = win_q;
        col_d      = col_q;
        col_cnt_d  = col_cnt_q;
        idx_d      = idx_q;
        mod_d      = mod_q;
        rcon_d     = rcon_q;
        round_d    = round_q;
        rk_valid_d = rk_valid_q;
        rk_data_d  = rk_data_q;
        rk_index_d = rk_index_q;
        rk_last_d  = rk_last_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_EXPAND;
                    for (int unsigned j = 0; j < NK; j++) begin
                        win_d[j] = key_in[32*j +: 32];
                    end
                    idx_d     = '0;
                    mod_d     = '0;
                    col_cnt_d = '0;
                    round_d   = '0;
                    rcon_d    = 8'h01;
                end
            end
            ST_EXPAND: begin
                if (rk_fire) begin
                    rk_valid_d = 1'b0;
                    rk_last_d  = 1'b0;
                end
                if (gen) begin
                    for (int unsigned j = 0; j < NK - 1; j++) begin
                        win_d[j] = win_q[j+1];
                    end
                    win_d[NK-1] = new_word;
                    idx_d = idx_q + 6'd1;
                    mod_d = (mod_q == NK_M1_W) ? 3'd0 : mod_q + 3'd1;
                    if (idx_q >= NK_W && mod_q == 3'd0) begin
                        rcon_d = xtime(rcon_q);
                    end
                    if (col_cnt_q == 2'd3) begin
                        rk_data_d  = {new_word, col_q[2], col_q[1], col_q[0]};
                        rk_valid_d = 1'b1;
                        rk_index_d = round_q;
                        rk_last_d  = (round_q == NR_W);
                        if (round_q != NR_W) begin
                            round_d = round_q + 4'd1;
                        end
                        col_cnt_d  = '0;
                    end else begin
                        for (int unsigned j = 0; j < 3; j++) begin
                            if (col_cnt_q == 2'(j)) begin
                                col_d[j] = new_word;
                            end
                        end
                        col_cnt_d = col_cnt_q + 2'd1;
                    end
                end
                if (last_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d    = ST_IDLE;
            rk_valid_d = 1'b0;
            rk_last_d  = 1'b0;
            rk_index_d = '0;
            idx_d      = '0;
            mod_d      = '0;
            col_cnt_d  = '0;
            round_d    = '0;
        end

`ifdef AES_KS_ZEROIZE_EN
        if (flush || last_fire) begin
            for (int unsigned j = 0; j < NK; j++) begin
                win_d[j] = '0;
            end
            for (int unsigned j = 0; j < 3; j++) begin
                col_d[j] = '0;
            end
            rk_data_d = '0;
            rcon_d    = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ready_en_q <= 1'b0;
            for (int unsigned j = 0; j < NK; j++) begin
                win_q[j] <= '0;
            end
            for (int unsigned j = 0; j < 3; j++) begin
                col_q[j] <= '0;
            end
            col_cnt_q  <= '0;
            idx_q      <= '0;
            mod_q      <= '0;
            rcon_q     <= '0;
            round_q    <= '0;
            rk_valid_q <= 1'b0;
            rk_data_q  <= '0;
            rk_index_q <= '0;
            rk_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= ready_en_d;
            win_q      <= win_d;
            col_q      <= col_d;
            col_cnt_q  <= col_cnt_d;
            idx_q      <= idx_d;
            mod_q      <= mod_d;
            rcon_q     <= rcon_d;
            round_q    <= round_d;
            rk_valid_q <= rk_valid_d;
            rk_data_q  <= rk_data_d;
            rk_index_q <= rk_index_d;
            rk_last_q  <= rk_last_d;
        end
    end

    assign key_ready = (state_q == ST_IDLE) && ready_en_q;
    assign rk_valid  = rk_valid_q;
    assign rk_data   = rk_data_q;
    assign rk_index  = rk_index_q;
    assign rk_last   = rk_last_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule
//   Drives three key schedules (128/192/256-bit) and checks every round key
//   against a reference expansion built from GF(2^8) arithmetic, plus known
//   FIPS-197 words, back-pressure, flush and asynchronous reset sequences.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid [3];
    logic         key_ready [3];
    logic [255:0] key_in    [3];
    logic         flush     [3];
    logic         rk_valid  [3];
    logic         rk_ready  [3];
    logic [127:0] rk_data   [3];
    logic [3:0]   rk_index  [3];
    logic         rk_last   [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned KB = 128 + 64 * g;
        aes_key_schedule #(.KEY_BITS(KB)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_valid (key_valid[g]),
            .key_ready (key_ready[g]),
            .key_in    (key_in[g][KB-1:0]),
            .flush     (flush[g]),
            .rk_valid  (rk_valid[g]),
            .rk_ready  (rk_ready[g]),
            .rk_data   (rk_data[g]),
            .rk_index  (rk_index[g]),
            .rk_last   (rk_last[g])
        );
    end

    int tests = 0;
    int fails = 0;

    logic [7:0]  sbox_ref [256];
    logic [31:0] model_w  [3][60];
    logic [31:0] got_w    [3][60];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        logic hi;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = aa << 1;
            if (hi) aa = aa ^ 8'h1b;
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box = affine transform of the multiplicative inverse (x^254).
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int n = 0; n < 254; n++) inv = gmul(inv, 8'(x));
            if (x == 0) inv = 8'h00;
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox_ref[t[8*b +: 8]];
        return r;
    endfunction

    task automatic compute_model(input int k, input logic [255:0] key);
        int nk = 4 + 2 * k;
        int nw = 4 * (nk + 7);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < nw; i++) begin
            if (i < nk) begin
                model_w[k][i] = key[32*i +: 32];
            end else begin
                t = model_w[k][i-1];
                if (i % nk == 0) begin
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk == 8 && i % nk == 4) begin
                    t = subw(t);
                end
                model_w[k][i] = model_w[k][i-nk] ^ t;
            end
        end
    endtask

    // ---------------- schedule driver ----------------
    // mode 0: rk_ready always 1; mode 1: random rk_ready; mode 2: 10-cycle
    // stall at round stall_r. stop_r >= 0 returns when round stop_r is shown.
    task automatic run_schedule(input int k, input logic [255:0] key, input int mode,
                                input int stall_r, input int stop_r);
        int nr = 10 + 2 * k;
        int nw = 4 * (nr + 1);
        int r = 0, cyc = 0, stall_cnt = 0, waitc = 0;
        int first_valid = -1, last_seen = -1;
        logic rdy;
        logic prev_hold = 1'b0;
        logic [127:0] prev_data;
        logic [3:0]   prev_idx;
        compute_model(k, key);
        while (!key_ready[k] && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("key_ready_idle", 128'(key_ready[k]), 128'd1);
        key_in[k]    = key;
        key_valid[k] = 1'b1;
        rk_ready[k]  = 1'b1;
        @(negedge clk);
        key_valid[k] = 1'b0;
        key_in[k]    = 256'(32'hdead_beef);
        chk("key_ready_busy", 128'(key_ready[k]), 128'd0);
        while (r <= nr && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (prev_hold) begin
                chk("hold_valid", 128'(rk_valid[k]), 128'd1);
                chk("hold_data", rk_data[k], prev_data);
                chk("hold_index", 128'(rk_index[k]), 128'(prev_idx));
            end
            prev_hold = 1'b0;
            if (rk_valid[k]) begin
                if (first_valid < 0) first_valid = cyc;
                if (r == nr && last_seen < 0) last_seen = cyc;
                if (stop_r == r) begin
                    rk_ready[k] = 1'b0;
                    return;
                end
                case (mode)
                    1:       rdy = 1'($urandom_range(0, 1));
                    2:       rdy = !(r == stall_r && stall_cnt < 10);
                    default: rdy = 1'b1;
                endcase
                if (!rdy && mode == 2) stall_cnt++;
                rk_ready[k] = rdy;
                if (rdy) begin
                    chk("rk_data", rk_data[k], {model_w[k][4*r+3], model_w[k][4*r+2],
                                                model_w[k][4*r+1], model_w[k][4*r]});
                    chk("rk_index", 128'(rk_index[k]), 128'(r));
                    chk("rk_last", 128'(rk_last[k]), 128'(r == nr));
                    for (int j = 0; j < 4; j++) got_w[k][4*r+j] = rk_data[k][32*j +: 32];
                    r++;
                end else begin
                    prev_hold = 1'b1;
                    prev_data = rk_data[k];
                    prev_idx  = rk_index[k];
                end
            end else begin
                rk_ready[k] = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        chk("schedule_complete", 128'(r), 128'(nr + 1));
        @(negedge clk);
        chk("valid_drop_after_last", 128'(rk_valid[k]), 128'd0);
        chk("key_ready_after_last", 128'(key_ready[k]), 128'd1);
`ifdef AES_KS_ZEROIZE_EN
        chk("zeroize_after_last", rk_data[k], 128'd0);
`endif
        if (mode == 0) begin
            chk("first_latency", 128'(first_valid), 128'd4);
            chk("last_latency", 128'(last_seen), 128'(nw));
        end
    endtask

    typedef struct {
        int           k;
        logic [255:0] key;
        int           widx;
        logic [31:0]  word;
    } vec_t;

    localparam logic [255:0] KEY128 = 256'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    localparam logic [255:0] KEY192 =
        256'h522c6b7b_62f8ead2_809079e5_c810f32b_da0e6452_8e73b0f7;
    localparam logic [255:0] KEY256 =
        256'h0914dff4_2d9810a3_3b6108d7_1f352c07_857d7781_2b73aef0_15ca71be_603deb10;

    vec_t tbl [7];

    initial begin
        logic acc;
        tbl[0] = '{k: 0, key: KEY128, widx: 4,  word: 32'ha0fafe17};
        tbl[1] = '{k: 0, key: KEY128, widx: 40, word: 32'hd014f9a8};
        tbl[2] = '{k: 0, key: KEY128, widx: 42, word: 32'he13f0cc8};
        tbl[3] = '{k: 0, key: KEY128, widx: 43, word: 32'hb6630ca6};
        tbl[4] = '{k: 1, key: KEY192, widx: 51, word: 32'h01002202};
        tbl[5] = '{k: 2, key: KEY256, widx: 12, word: 32'ha8b09c1a};
        tbl[6] = '{k: 2, key: KEY256, widx: 59, word: 32'h706c631e};

        for (int k = 0; k < 3; k++) begin
            key_valid[k] = 1'b0;
            key_in[k]    = '0;
            flush[k]     = 1'b0;
            rk_ready[k]  = 1'b0;
        end
        build_sbox();

        // reset state
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_key_ready", 128'(key_ready[k]), 128'd0);
            chk("rst_rk_valid", 128'(rk_valid[k]), 128'd0);
            chk("rst_rk_data", rk_data[k], 128'd0);
            chk("rst_rk_index", 128'(rk_index[k]), 128'd0);
            chk("rst_rk_last", 128'(rk_last[k]), 128'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // known-answer table
        for (int t = 0; t < 7; t++) begin
            run_schedule(tbl[t].k, tbl[t].key, 0, -1, -1);
            chk($sformatf("table_w%0d_k%0d", tbl[t].widx, tbl[t].k),
                128'(got_w[tbl[t].k][tbl[t].widx]), 128'(tbl[t].word));
        end

        // back-pressure at round 3
        run_schedule(0, KEY128, 2, 3, -1);

        // randomized keys and rk_ready
        for (int n = 0; n < 6; n++) begin
            logic [255:0] rk;
            for (int j = 0; j < 8; j++) rk[32*j +: 32] = $urandom;
            run_schedule(n % 3, rk, 1, -1, -1);
        end

        // flush together with key_valid in IDLE: key must not be taken
        key_in[1] = KEY192; key_valid[1] = 1'b1; flush[1] = 1'b1;
        @(negedge clk);
        key_valid[1] = 1'b0; flush[1] = 1'b0;
        chk("flush_idle_ready", 128'(key_ready[1]), 128'd1);
        acc = 1'b0;
        repeat (8) begin
            @(negedge clk);
            acc = acc | rk_valid[1];
        end
        chk("flush_idle_no_valid", 128'(acc), 128'd0);

        // flush mid-expansion at round 5, new key right after
        run_schedule(0, KEY128, 0, -1, 5);
        flush[0] = 1'b1;
        @(negedge clk);
        flush[0] = 1'b0;
        chk("flush_valid", 128'(rk_valid[0]), 128'd0);
        chk("flush_last", 128'(rk_last[0]), 128'd0);
        chk("flush_key_ready", 128'(key_ready[0]), 128'd1);
`ifdef AES_KS_ZEROIZE_EN
        chk("flush_zeroize", rk_data[0], 128'd0);
`endif
        run_schedule(0, KEY256, 0, -1, -1);

        // asynchronous reset at round 7
        run_schedule(0, KEY128, 0, -1, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rk_valid", 128'(rk_valid[0]), 128'd0);
        chk("arst_rk_data", rk_data[0], 128'd0);
        chk("arst_rk_index", 128'(rk_index[0]), 128'd0);
        chk("arst_rk_last", 128'(rk_last[0]), 128'd0);
        chk("arst_key_ready", 128'(key_ready[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_release_ready", 128'(key_ready[0]), 128'd1);
        run_schedule(0, KEY128, 0, -1, -1);
        chk("arst_rerun_w4", 128'(got_w[0][4]), 128'(32'ha0fafe17));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
